// File: rtl/mmio_pkg.sv
// Shared definitions for the MMIO fabric: window offsets, write-alias modes
// and the read-modify-write helper used by the output registers.
package mmio_pkg;

  localparam logic [8:0] OFF_IN     = 9'h100;
  localparam logic [8:0] OFF_STATUS = 9'h180;
  localparam logic [8:0] OFF_ERR    = 9'h184;

  typedef enum logic [1:0] {
    WR_WRITE = 2'b00,
    WR_SET   = 2'b01,
    WR_CLR   = 2'b10,
    WR_TGL   = 2'b11
  } wr_mode_t;

  function automatic logic [31:0] apply_mode(input logic [31:0] old,
                                             input logic [31:0] operand,
                                             input wr_mode_t    mode);
    logic [31:0] res;
    case (mode)
      WR_WRITE: res = operand;
      WR_SET:   res = old | operand;
      WR_CLR:   res = old & ~operand;
      WR_TGL:   res = old ^ operand;
      default:  res = old;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/mmio_in_capture.sv
// One input channel: sample register plus sticky new-data flag.
// A fresh sample always wins over a clear landing in the same cycle.
module mmio_in_capture
  import mmio_pkg::*;
#(
  parameter int W = 17
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         valid,
  input  logic         clear,
  input  logic [W-1:0] sample,
  output logic [W-1:0] data,
  output logic         flag
);

  // Sample capture and flag set/clear
  always_ff @(posedge clk) begin
    if (reset) begin
      data <= '0;
      flag <= 1'b0;
    end else begin
      if (valid) begin
        data <= sample;
        flag <= 1'b1;
      end else if (clear) begin
        flag <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/mmio_fabric.sv
// Windowed MMIO fabric: output registers with set/clear/toggle aliases,
// sampled input channels, status flags and a sticky unmapped-access counter.
module mmio_fabric
  import mmio_pkg::*;
#(
  parameter logic [31:0] IO_BASE = 32'h0000_0800,
  parameter int          NUM_OUT = 4,
  parameter int          OUT_W   = 16,
  parameter int          NUM_IN  = 2,
  parameter int          IN_W    = 17,
  parameter logic [31:0] OUT_RST = 32'h0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     memWrite,
  input  logic                     memRead,
  input  logic [31:0]              address,
  input  logic [31:0]              writeData,
  output logic [31:0]              readData,
  output logic                     dmem_we,
  input  logic [31:0]              dmem_rdata,
  output logic [NUM_OUT*OUT_W-1:0] out_regs,
  input  logic [NUM_IN*IN_W-1:0]   in_data,
  input  logic [NUM_IN-1:0]        in_valid
);

  localparam logic [4:0] NUM_OUT_L = 5'(NUM_OUT);
  localparam logic [4:0] NUM_IN_L  = 5'(NUM_IN);

  logic [OUT_W-1:0]  out_q [NUM_OUT];
  logic [IN_W-1:0]   samples [NUM_IN];
  logic [NUM_IN-1:0] flags;
  logic [NUM_IN-1:0] clr;
  logic              err_flag;
  logic [15:0]       err_cnt;

  logic [8:0]  off;
  logic [3:0]  idx;
  logic        hit, out_ok, in_sel, in_ok, is_status, is_err;
  logic        mapped_rd, mapped_wr, unmapped_access;
  logic [31:0] out_rd, in_rd, io_rd, mode_res;
  logic [OUT_W-1:0] out_next;
  logic        unused_bits;

  assign off       = address[8:0];
  assign idx       = off[5:2];
  assign hit       = (address[31:9] == IO_BASE[31:9]);
  assign out_ok    = hit && !off[8] && ({1'b0, idx} < NUM_OUT_L);
  assign in_sel    = hit && (off[8:7] == OFF_IN[8:7]);
  assign in_ok     = in_sel && ({1'b0, idx} < NUM_IN_L);
  assign is_status = hit && (off[8:2] == OFF_STATUS[8:2]);
  assign is_err    = hit && (off[8:2] == OFF_ERR[8:2]);

  // IN channels are read-only, so a store there counts as unmapped
  assign mapped_rd       = out_ok || in_ok || is_status || is_err;
  assign mapped_wr       = out_ok || is_status || is_err;
  assign unmapped_access = hit && ((memRead && !mapped_rd) || (memWrite && !mapped_wr));

  assign dmem_we     = memWrite && !hit;
  assign readData    = hit ? io_rd : dmem_rdata;
  assign mode_res    = apply_mode(out_rd, writeData, wr_mode_t'(off[7:6]));
  assign out_next    = OUT_W'(mode_res);
  assign unused_bits = ^{off[1:0], off[6], mode_res};

  // Selected OUT register and IN sample, zero-extended
  always_comb begin
    out_rd = 32'h0;
    in_rd  = 32'h0;
    for (int i = 0; i < NUM_OUT; i++) begin
      out_rd = out_rd | ((idx == 4'(i)) ? 32'(out_q[i]) : 32'h0);
    end
    for (int i = 0; i < NUM_IN; i++) begin
      in_rd = in_rd | ((idx == 4'(i)) ? 32'(samples[i]) : 32'h0);
    end
  end

  // In-window read mux; unmapped offsets read as zero
  always_comb begin
    io_rd = 32'h0;
    if (out_ok) begin
      io_rd = out_rd;
    end else if (in_ok) begin
      io_rd = in_rd;
    end else if (is_status) begin
      io_rd = 32'(flags);
    end else if (is_err) begin
      io_rd = {err_flag, 15'h0, err_cnt};
    end else begin
      io_rd = 32'h0;
    end
  end

  // OUT register array with write/set/clear/toggle aliases
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_OUT; i++) out_q[i] <= OUT_RST[OUT_W-1:0];
    end else if (memWrite && out_ok) begin
      for (int i = 0; i < NUM_OUT; i++) begin
        if (idx == 4'(i)) out_q[i] <= out_next;
      end
    end
  end

  // Sticky error and saturating unmapped-access count
  always_ff @(posedge clk) begin
    if (reset) begin
      err_flag <= 1'b0;
      err_cnt  <= 16'h0;
    end else if (is_err && memWrite) begin
      err_flag <= 1'b0;
      err_cnt  <= 16'h0;
    end else if (unmapped_access) begin
      err_flag <= 1'b1;
      if (err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
    end
  end

  for (genvar g = 0; g < NUM_OUT; g++) begin : g_out
    assign out_regs[g*OUT_W +: OUT_W] = out_q[g];
  end

  // Status read clears the flags it returned; W1C clears the written ones
  for (genvar g = 0; g < NUM_IN; g++) begin : g_in
    assign clr[g] = is_status && ((memRead && flags[g]) || (memWrite && writeData[g]));

    mmio_in_capture #(.W(IN_W)) u_cap (
      .clk    (clk),
      .reset  (reset),
      .valid  (in_valid[g]),
      .clear  (clr[g]),
      .sample (in_data[g*IN_W +: IN_W]),
      .data   (samples[g]),
      .flag   (flags[g])
    );
  end

endmodule
